// File: rtl/fb_muldiv.sv
// rtl/fb_muldiv.sv - iterative RV32M multiply/divide unit; FB_MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module fb_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [7:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [7:0]      op_q;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    logic            neg_a;
    logic            neg_b;

    logic [7:0]      op_pri;
    logic            accept;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            is_div, is_rem, div_zero, div_ovf;
    logic [XLEN-1:0] special_res;
    logic            is_div_q;
    logic [XLEN:0]   rs;
    logic            ge;
    logic [XLEN-1:0] dhi, dlo, nhi, nlo;
    logic [XLEN-1:0] fin_res;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE) && !flush;
    assign accept    = in_valid && in_ready && !flush && (op != 8'd0);

    // Highest-numbered op bit wins when several are set.
    always_comb begin
        op_pri = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (op[i]) begin
                op_pri    = 8'd0;
                op_pri[i] = 1'b1;
            end
        end
    end

    always_comb begin
        a_signed    = op_pri[6] | op_pri[5] | op_pri[3] | op_pri[1];
        b_signed    = op_pri[6] | op_pri[3] | op_pri[1];
        a_neg       = a_signed & src_a[XLEN-1];
        b_neg       = b_signed & src_b[XLEN-1];
        abs_a       = a_neg ? -src_a : src_a;
        abs_b       = b_neg ? -src_b : src_b;
        is_div      = |op_pri[3:0];
        is_rem      = op_pri[1] | op_pri[0];
        div_zero    = is_div && (src_b == '0);
        div_ovf     = (op_pri[3] | op_pri[1]) && (src_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (src_b == '1);
        if (div_zero)
            special_res = is_rem ? src_a : '1;
        else
            special_res = is_rem ? '0 : src_a;
    end

`ifdef FB_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_ea, fast_eb, fast_prod;
    logic [XLEN-1:0]   fast_res;

    // Operands extended to 2*XLEN so the truncated product is the exact signed result.
    always_comb begin
        fast_ea   = {{XLEN{a_signed & src_a[XLEN-1]}}, src_a};
        fast_eb   = {{XLEN{b_signed & src_b[XLEN-1]}}, src_b};
        fast_prod = fast_ea * fast_eb;
        fast_res  = op_pri[7] ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // Restoring divide step: hi = partial remainder, lo = dividend shifting into quotient.
    always_comb begin
        is_div_q = |op_q[3:0];
        rs       = {hi, lo[XLEN-1]};
        ge       = rs >= {1'b0, opnd};
        dhi      = ge ? (rs[XLEN-1:0] - opnd) : rs[XLEN-1:0];
        dlo      = {lo[XLEN-2:0], ge};
    end

`ifdef FB_MULDIV_FAST_MUL_EN
    always_comb begin
        nhi     = dhi;
        nlo     = dlo;
        fin_res = '0;
        if (op_q[3] | op_q[2])
            fin_res = (neg_a ^ neg_b) ? -nlo : nlo;
        else
            fin_res = neg_a ? -nhi : nhi;
    end
`else
    logic [XLEN:0]     msum;
    logic [2*XLEN-1:0] prod;

    // Shift-add multiply step: hi accumulates, lo holds the multiplier shifting out.
    always_comb begin
        msum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        if (is_div_q) begin
            nhi = dhi;
            nlo = dlo;
        end else begin
            nhi = msum[XLEN:1];
            nlo = {msum[0], lo[XLEN-1:1]};
        end
        prod = {nhi, nlo};
        if (neg_a ^ neg_b)
            prod = -prod;
        if (op_q[7])
            fin_res = prod[XLEN-1:0];
        else if (|op_q[6:4])
            fin_res = prod[2*XLEN-1:XLEN];
        else if (op_q[3] | op_q[2])
            fin_res = (neg_a ^ neg_b) ? -nlo : nlo;
        else
            fin_res = neg_a ? -nhi : nhi;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op_pri;
                        neg_a <= a_neg;
                        neg_b <= b_neg;
                        cnt   <= CW'(XLEN - 1);
                        hi    <= '0;
                        lo    <= is_div ? abs_a : abs_b;
                        opnd  <= is_div ? abs_b : abs_a;
                        if (div_zero || div_ovf) begin
                            result <= special_res;
                            state  <= DONE;
                        end
`ifdef FB_MULDIV_FAST_MUL_EN
                        else if (!is_div) begin
                            result <= fast_res;
                            state  <= DONE;
                        end
`endif
                        else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi  <= nhi;
                    lo  <= nlo;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result <= fin_res;
                        state  <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_muldiv.sv
// tb/tb_fb_muldiv.sv - directed self-checking bench for fb_muldiv
module tb_fb_muldiv;

    localparam int XLEN = 32;
`ifdef FB_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    localparam logic [7:0] OP_MUL    = 8'h80;
    localparam logic [7:0] OP_MULH   = 8'h40;
    localparam logic [7:0] OP_MULHSU = 8'h20;
    localparam logic [7:0] OP_MULHU  = 8'h10;
    localparam logic [7:0] OP_DIV    = 8'h08;
    localparam logic [7:0] OP_DIVU   = 8'h04;
    localparam logic [7:0] OP_REM    = 8'h02;
    localparam logic [7:0] OP_REMU   = 8'h01;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [7:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic            busy;

    int total;
    int bad;

    fb_muldiv #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        step();
        in_valid = 1'b0;
        op       = 8'd0;
        src_a    = '0;
        src_b    = '0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bit got;
        issue(o, a, b);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            step();
            lat++;
        end
        check({tag, "_seen"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, exp);
        step();
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        op       = 8'd0;
        src_a    = '0;
        src_b    = '0;
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        step();

        run_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
        run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);
        run_op("div_zero", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("remu_zero", OP_REMU, 32'd5, 32'd0, 32'd5, 1);

        // Flush mid-divide at T+10.
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 36; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("flush_no_valid", 32'(seen), 32'd0);
        check("flush_result", result, 32'd5);

        // Flush together with in_valid blocks the request.
        flush = 1'b1;
        issue(OP_DIV, 32'd100, 32'd7);
        flush = 1'b0;
        check("flush_accept_busy", 32'(busy), 32'd0);

        // Flush in DONE suppresses out_valid.
        issue(OP_DIVU, 32'd9, 32'd0);
        flush = 1'b1;
        #1;
        check("flush_done_valid", 32'(out_valid), 32'd0);
        step();
        flush = 1'b0;
        check("flush_done_busy", 32'(busy), 32'd0);

        // Reset mid-divu at T+5.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_result", result, 32'd0);

        // op == 0 is ignored.
        issue(8'd0, 32'd1, 32'd1);
        check("op0_busy", 32'(busy), 32'd0);

        // mul | div together: mul wins.
        run_op("mul_pri", OP_MUL | OP_DIV, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
